// File: rtl/game_controller_pkg.sv
// Shared definitions for the memory-game controller: state codes, command bundle, decode helper.
package game_controller_pkg;

  localparam int unsigned P_STATE_W = 3;

  typedef enum logic [P_STATE_W-1:0] {
    ST_INIT       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_PREP       = 3'd2,
    ST_PLAY_FPGA  = 3'd3,
    ST_PLAY_USER  = 3'd4,
    ST_CHECK      = 3'd5,
    ST_NEXT_ROUND = 3'd6,
    ST_RESULT     = 3'd7
  } state_t;

  // Datapath command bundle, MSB first: {r1, r2, e1, e2, e3, e4, sel}
  typedef struct packed {
    logic r1;
    logic r2;
    logic e1;
    logic e2;
    logic e3;
    logic e4;
    logic sel;
  } cmd_t;

  localparam cmd_t CMD_NONE = '0;

  // Moore decode: commands asserted while sitting in a given state
  function automatic cmd_t state_cmd(input state_t st);
    cmd_t c;
    c     = CMD_NONE;
    c.sel = 1'b1;
    case (st)
      ST_INIT:       begin c.r1 = 1'b1; c.r2 = 1'b1; end
      ST_SETUP:      c.e1 = 1'b1;
      ST_PREP:       c.r2 = 1'b1;
      ST_PLAY_FPGA:  c.e3 = 1'b1;
      ST_PLAY_USER:  c.e2 = 1'b1;
      ST_CHECK:      c.sel = 1'b1;
      ST_NEXT_ROUND: c.e4 = 1'b1;
      ST_RESULT:     c.sel = 1'b0;
      default:       c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/game_controller_if.sv
// Command/status lines between the game controller and the game datapath.
interface game_controller_if;
  logic r1;
  logic r2;
  logic e1;
  logic e2;
  logic e3;
  logic e4;
  logic sel;
  logic end_fpga;
  logic end_user;
  logic end_time;
  logic win;
  logic match;

  modport master (
    output r1, r2, e1, e2, e3, e4, sel,
    input  end_fpga, end_user, end_time, win, match
  );

  modport slave (
    input  r1, r2, e1, e2, e3, e4, sel,
    output end_fpga, end_user, end_time, win, match
  );
endinterface

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer for an active-low push key plus a one-cycle press detector.
module key_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_c
);

  logic sync1_q;
  logic key_d_q;
  logic key_prev_q;

  // Reset to the released level so reset release never fakes a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      key_d_q    <= 1'b1;
      key_prev_q <= 1'b1;
    end else begin
      sync1_q    <= key_n;
      key_d_q    <= sync1_q;
      key_prev_q <= key_d_q;
    end
  end

  assign press_c = key_prev_q & ~key_d_q;

endmodule

// File: rtl/game_controller.sv
// Control FSM for the memory-sequence game; commands are registered alongside the state.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int unsigned P_SETTLE = 2
) (
  input  logic                 clock_50,
  input  logic                 reset,
  input  logic                 enter,
  game_controller_if.master    dp,
  output logic [P_STATE_W-1:0] dbg_state
);

  localparam int unsigned CNT_W = (P_SETTLE > 1) ? $clog2(P_SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(P_SETTLE - 1);

  logic             press_c;
  state_t           state_q;
  state_t           state_d;
  cmd_t             cmd_q;
  cmd_t             cmd_d;
  logic [CNT_W-1:0] settle_q;

  key_edge_sync u_enter_sync (
    .clk     (clock_50),
    .rst_n   (reset),
    .key_n   (enter),
    .press_c (press_c)
  );

  // Commands are decoded from the next state so they line up with state_q exactly
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT;
      cmd_q    <= state_cmd(ST_INIT);
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      settle_q <= (state_q == ST_PREP) ? settle_q + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:       state_d = ST_SETUP;
      ST_SETUP:      if (press_c) state_d = ST_PREP;
      ST_PREP:       if (settle_q == SETTLE_LAST) state_d = ST_PLAY_FPGA;
      ST_PLAY_FPGA:  if (dp.end_fpga) state_d = ST_PLAY_USER;
      ST_PLAY_USER: begin
        if (dp.end_time)      state_d = ST_RESULT;
        else if (dp.end_user) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!dp.match)   state_d = ST_RESULT;
        else if (dp.win) state_d = ST_RESULT;
        else             state_d = ST_NEXT_ROUND;
      end
      ST_NEXT_ROUND: state_d = ST_PREP;
      ST_RESULT:     if (press_c) state_d = ST_INIT;
      default:       state_d = ST_INIT;
    endcase
    cmd_d = state_cmd(state_d);
  end

  assign dp.r1     = cmd_q.r1;
  assign dp.r2     = cmd_q.r2;
  assign dp.e1     = cmd_q.e1;
  assign dp.e2     = cmd_q.e2;
  assign dp.e3     = cmd_q.e3;
  assign dp.e4     = cmd_q.e4;
  assign dp.sel    = cmd_q.sel;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: directed game scenarios plus randomized play.
module tb_game_controller;

  localparam int P_SETTLE = 2;

  localparam int S_INIT = 0, S_SETUP = 1, S_PREP = 2, S_FPGA = 3,
                 S_USER = 4, S_CHECK = 5, S_NEXT = 6, S_RESULT = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enter = 1'b1;
  logic [2:0] dbg_state;

  game_controller_if dp_if ();

  game_controller #(.P_SETTLE(P_SETTLE)) dut (
    .clock_50  (clk),
    .reset     (rst_n),
    .enter     (enter),
    .dp        (dp_if),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [9:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: game phase, settle cycles left, last three raw key levels
  int   m_state = S_INIT;
  int   m_settle_left = 0;
  logic h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;

  // Commands {r1,r2,e1,e2,e3,e4,sel} expected in each game phase
  function automatic logic [6:0] phase_cmd(input int st);
    case (st)
      S_INIT:   return 7'b1100001;
      S_SETUP:  return 7'b0010001;
      S_PREP:   return 7'b0100001;
      S_FPGA:   return 7'b0000101;
      S_USER:   return 7'b0001001;
      S_CHECK:  return 7'b0000001;
      S_NEXT:   return 7'b0000011;
      default:  return 7'b0000000;
    endcase
  endfunction

  // One clock of stimulus; records what the DUT must show during this cycle
  task automatic step(input logic rn, input logic en, input logic ef, input logic eu,
                      input logic et, input logic w, input logic m);
    logic press;
    @(posedge clk);
    #1;
    rst_n          = rn;
    enter          = en;
    dp_if.end_fpga = ef;
    dp_if.end_user = eu;
    dp_if.end_time = et;
    dp_if.win      = w;
    dp_if.match    = m;
    cyc++;
    if (!rn) begin
      m_state = S_INIT;
      h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
    end
    exp_q.push_back({3'(m_state), phase_cmd(m_state)});
    if (rn) begin
      // The FSM sees a press once the 1->0 key transition has crossed the synchronizer
      press = h3 & ~h2;
      case (m_state)
        S_INIT:   m_state = S_SETUP;
        S_SETUP:  if (press) begin m_state = S_PREP; m_settle_left = P_SETTLE; end
        S_PREP: begin
          m_settle_left--;
          if (m_settle_left == 0) m_state = S_FPGA;
        end
        S_FPGA:   if (ef) m_state = S_USER;
        S_USER:   if (et) m_state = S_RESULT; else if (eu) m_state = S_CHECK;
        S_CHECK:  m_state = (!m || w) ? S_RESULT : S_NEXT;
        S_NEXT:   begin m_state = S_PREP; m_settle_left = P_SETTLE; end
        default:  if (press) m_state = S_INIT;
      endcase
      h3 = h2; h2 = h1; h1 = en;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic press_key();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard every cycle away from the edge
  initial begin
    logic [9:0] exp_v;
    logic [9:0] act_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {dbg_state, dp_if.r1, dp_if.r2, dp_if.e1, dp_if.e2,
                 dp_if.e3, dp_if.e4, dp_if.sel};
        n_tests++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL state_cmd cycle %0d: actual state=%0d cmd=%b, required state=%0d cmd=%b",
                   cyc, act_v[9:7], act_v[6:0], exp_v[9:7], exp_v[6:0]);
        end
      end
    end
  end

  initial begin
    int hold;
    logic en_r;
    dp_if.end_fpga = 1'b0;
    dp_if.end_user = 1'b0;
    dp_if.end_time = 1'b0;
    dp_if.win      = 1'b0;
    dp_if.match    = 1'b0;

    // Reset, then idle in SETUP
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
    idle(1000);

    // Long hold gives a single press: PREP then PLAY_FPGA
    for (int i = 0; i < 500; i++) step(1, 0, 0, 0, 0, 0, 0);
    idle(5);

    // FPGA done, user round ok, not final -> NEXT_ROUND -> PREP -> PLAY_FPGA
    step(1, 1, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 1, 0, 1, 0, 0, 1);
    idle(8);

    // Timeout and end_user together -> RESULT
    step(1, 1, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 1, 0, 1, 1, 0, 1);
    idle(3);

    // Leave RESULT, new game, win on the final round
    press_key();
    press_key();
    idle(3);
    step(1, 1, 1, 0, 0, 0, 0);
    idle(1);
    step(1, 1, 0, 1, 0, 1, 1);
    idle(3);

    // New game, mismatch loss
    press_key();
    press_key();
    idle(3);
    step(1, 1, 1, 0, 0, 0, 0);
    idle(1);
    step(1, 1, 0, 1, 0, 0, 0);
    idle(3);

    // Reset in the middle of PLAY_FPGA
    press_key();
    press_key();
    idle(3);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(5);

    // Randomized play
    hold = 0;
    en_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        en_r = ($urandom % 4) != 0;
        hold = $urandom_range(1, 20);
      end
      hold--;
      step(($urandom % 700) != 0, en_r,
           ($urandom % 6) == 0, ($urandom % 5) == 0, ($urandom % 12) == 0,
           ($urandom % 3) == 0, ($urandom % 3) != 0);
    end

    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
